face_detect_mul_arbiter: RTL and testbench

- Round-robin arbiter that shares one pipelined 16-bit unsigned × 6-bit signed multiplier (22-bit signed product) among NUM_REQ requesters.
- Used by face-detection feature-evaluation engines, which issue weighted-rectangle products.
- Issues at most one operand pair per cycle and drives the multiplier's clock enable.
- Tags each in-flight operation with its requester ID and returns the product with that ID.
- Stalls the whole multiplier pipeline when the result consumer backpressures.

---
 rtl/face_detect_mul_arbiter.sv | 92 +++++++++
 tb/tb_face_detect_mul_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/face_detect_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined 16u x 6s multiplier among NUM_REQ requesters.
// Each issued operand pair is tagged with its requester ID, and the tag pipeline moves with the multiplier's clock enable.
module face_detect_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*16-1:0]   req_din0,
    input  logic [NUM_REQ*6-1:0]    req_din1,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    mul_ce,
    output logic [15:0]             mul_din0,
    output logic signed [5:0]       mul_din1,
    input  logic signed [21:0]      mul_dout,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [ID_W-1:0]         res_id,
    output logic signed [21:0]      res_data,
    output logic                    busy
);

    logic [MUL_LAT-1:0] vld_q;
    logic [ID_W-1:0]    id_q [MUL_LAT];
    logic [ID_W-1:0]    rr_ptr_q;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [ID_W-1:0]    winner;
    logic               found;
    logic               issue;
    int                 scan_idx;

    // The last tag stage lines up with mul_dout, so the result is only a passthrough.
    assign res_valid = vld_q[MUL_LAT-1];
    assign res_id    = id_q[MUL_LAT-1];
    assign res_data  = mul_dout;
    assign mul_ce    = ~(res_valid & ~res_ready);
    assign busy      = |vld_q;

    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && req_valid[scan_idx]) begin
                found  = 1'b1;
                winner = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        issue     = found & mul_ce;
        req_ready = '0;
        mul_din0  = '0;
        mul_din1  = '0;
        rr_ptr_d  = rr_ptr_q;
        if (issue) begin
            req_ready = NUM_REQ'(1) << winner;
            mul_din0  = req_din0[int'(winner)*16 +: 16];
            mul_din1  = $signed(req_din1[int'(winner)*6 +: 6]);
            // Explicit wrap so non-power-of-two NUM_REQ never points at a missing requester.
            rr_ptr_d  = (int'(winner) == NUM_REQ-1) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q    <= '0;
            rr_ptr_q <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (mul_ce) begin
                vld_q[0] <= issue;
                id_q[0]  <= winner;
                for (int i = 1; i < MUL_LAT; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    id_q[i]  <= id_q[i-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_face_detect_mul_arbiter.sv
// Directed bench for face_detect_mul_arbiter with a 3-stage clock-enabled multiplier model.
module tb_face_detect_mul_arbiter;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         req_valid;
    logic [63:0]        req_din0;
    logic [23:0]        req_din1;
    logic [3:0]         req_ready;
    logic               mul_ce;
    logic [15:0]        mul_din0;
    logic signed [5:0]  mul_din1;
    logic signed [21:0] mul_dout;
    logic               res_valid;
    logic               res_ready;
    logic [1:0]         res_id;
    logic signed [21:0] res_data;
    logic               busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic signed [21:0] m_q [3];
    logic signed [21:0] op_a;
    logic signed [21:0] op_b;

    face_detect_mul_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_din0  (req_din0),
        .req_din1  (req_din1),
        .req_ready (req_ready),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_id    (res_id),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Multiplier model sharing mul_ce; it is not reset, like the real core.
    assign op_a     = {6'b0, mul_din0};
    assign op_b     = {{16{mul_din1[5]}}, mul_din1};
    assign mul_dout = m_q[2];

    initial begin
        m_q[0] = '0;
        m_q[1] = '0;
        m_q[2] = '0;
    end

    always @(posedge clk) begin
        if (mul_ce) begin
            m_q[0] <= op_a * op_b;
            m_q[1] <= m_q[0];
            m_q[2] <= m_q[1];
        end
    end

    task automatic check_eq(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_din0[i*16 +: 16] = 16'(a);
        req_din1[i*6 +: 6]   = 6'(b);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic check_res(input string tag, input int id, input int data);
        check_eq({tag, "_vld"}, int'(res_valid), 1);
        check_eq({tag, "_id"}, int'(res_id), id);
        check_eq({tag, "_data"}, int'(res_data), data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_id;
        reset     = 1'b1;
        req_valid = '0;
        req_din0  = '0;
        req_din1  = '0;
        res_ready = 1'b1;
        cyc();
        cyc();
        #1;
        check_eq("rst_res_valid", int'(res_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_mul_ce", int'(mul_ce), 1);
        check_eq("rst_req_ready", int'(req_ready), 0);
        check_eq("rst_din0", int'(mul_din0), 0);
        check_eq("rst_din1", int'(mul_din1), 0);
        reset = 1'b0;

        // Single op from requester 2: 1000 * -3
        cyc();
        set_op(2, 1000, -3);
        req_valid = 4'b0100;
        #1;
        check_eq("single_ready", int'(req_ready), 4);
        check_eq("single_din0", int'(mul_din0), 1000);
        check_eq("single_din1", int'(mul_din1), -3);
        cyc();
        req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            check_eq("single_busy", int'(busy), (k <= 3) ? 1 : 0);
            if (k == 3) begin
                check_res("single_res", 2, -3000);
            end else begin
                check_eq("single_novld", int'(res_valid), 0);
            end
            cyc();
        end

        // All four requesters continuously valid from reset
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 100 * (i + 1), i - 2);
        for (int k = 0; k <= 12; k++) begin
            req_valid = (k < 10) ? 4'b1111 : 4'b0000;
            #1;
            check_eq("rr_ready", int'(req_ready), (k < 10) ? (1 << (k % 4)) : 0);
            if (k >= 3) begin
                exp_id = (k - 3) % 4;
                check_res("rr_res", exp_id, 100 * (exp_id + 1) * (exp_id - 2));
            end
            cyc();
        end

        // Backpressure with three ops in flight (rr_ptr is 2 here)
        set_op(0, 10, 3);
        set_op(1, 20, -4);
        set_op(3, 30, 5);
        set_op(2, 7, -1);
        req_valid = 4'b0001;
        #1;
        check_eq("bp_issue0", int'(req_ready), 1);
        cyc();
        req_valid = 4'b0010;
        #1;
        check_eq("bp_issue1", int'(req_ready), 2);
        cyc();
        req_valid = 4'b1000;
        #1;
        check_eq("bp_issue3", int'(req_ready), 8);
        cyc();
        req_valid = 4'b0100;
        res_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            #1;
            check_eq("bp_ce", int'(mul_ce), 0);
            check_eq("bp_ready", int'(req_ready), 0);
            check_eq("bp_busy", int'(busy), 1);
            check_res("bp_hold", 0, 30);
            cyc();
        end
        res_ready = 1'b1;
        #1;
        check_eq("bp_rel_ready", int'(req_ready), 4);
        check_res("bp_out0", 0, 30);
        cyc();
        req_valid = '0;
        #1;
        check_res("bp_out1", 1, -80);
        cyc();
        check_res("bp_out2", 3, 150);
        cyc();
        check_res("bp_out3", 2, -7);
        cyc();
        check_eq("bp_end_vld", int'(res_valid), 0);
        check_eq("bp_end_busy", int'(busy), 0);

        // Operand extremes back to back from requester 1
        set_op(1, 65535, -32);
        req_valid = 4'b0010;
        #1;
        check_eq("ext_din0", int'(mul_din0), 65535);
        check_eq("ext_din1", int'(mul_din1), -32);
        cyc();
        set_op(1, 65535, 31);
        cyc();
        set_op(1, 0, -1);
        cyc();
        req_valid = '0;
        #1;
        check_res("ext_min", 1, -2097120);
        cyc();
        check_res("ext_max", 1, 2031585);
        cyc();
        check_res("ext_zero", 1, 0);
        cyc();

        // Fairness: requester 0 always valid, requester 3 valid once
        do_reset();
        set_op(0, 5, 2);
        set_op(1, 3, 3);
        set_op(3, 9, -2);
        req_valid = 4'b1001;
        #1;
        check_eq("fair_g0", int'(req_ready), 1);
        cyc();
        check_eq("fair_g3", int'(req_ready), 8);
        cyc();
        req_valid = 4'b0011;
        #1;
        check_eq("fair_wrap", int'(req_ready), 1);
        cyc();
        check_eq("fair_g1", int'(req_ready), 2);
        check_res("fair_r0", 0, 10);
        cyc();
        req_valid = '0;
        #1;
        check_res("fair_r3", 3, -18);
        cyc();
        check_res("fair_r0b", 0, 10);
        cyc();
        check_res("fair_r1", 1, 9);
        cyc();

        // Asynchronous reset with two ops in flight
        set_op(0, 11, 1);
        set_op(1, 12, 1);
        req_valid = 4'b0001;
        cyc();
        req_valid = 4'b0010;
        cyc();
        req_valid = '0;
        cyc();
        check_res("rstf_pre", 0, 11);
        check_eq("rstf_pre_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check_eq("rstf_vld", int'(res_valid), 0);
        check_eq("rstf_busy", int'(busy), 0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            check_eq("rstf_stale", int'(res_valid), 0);
            check_eq("rstf_idle", int'(busy), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
